// File: rtl/divided_clock_memory_subsystem.sv
module divided_clock_memory_subsystem #(
  parameter int    DIV_HALF_PERIOD = 1,
  parameter int    ADDR_WIDTH      = 12,
  parameter int    DATA_WIDTH      = 32,
  parameter string ROM_MEMFILE     = ""
) (
  input  logic                  clock_in,
  input  logic                  reset,
  output logic                  clock_out,
  output logic                  tick,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  dmem_wen,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_data_in,
  output logic [DATA_WIDTH-1:0] dmem_data_out
);

  localparam int CNT_WIDTH = (DIV_HALF_PERIOD > 1) ? $clog2(DIV_HALF_PERIOD) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV_HALF_PERIOD - 1);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [CNT_WIDTH-1:0]  cnt;
  logic                  at_last;
  logic [DATA_WIDTH-1:0] rom [DEPTH];
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
  end

  assign at_last = (cnt == CNT_LAST);
  assign tick    = at_last && !clock_out;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt       <= '0;
      clock_out <= 1'b0;
    end else if (at_last) begin
      cnt       <= '0;
      clock_out <= ~clock_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      imem_data     <= '0;
      dmem_data_out <= '0;
    end else if (tick) begin
      imem_data <= rom[imem_addr];
      if (dmem_wen) ram[dmem_addr] <= dmem_data_in;
`ifdef MEM_WRITE_THROUGH_EN
      dmem_data_out <= dmem_wen ? dmem_data_in : ram[dmem_addr];
`else
      dmem_data_out <= ram[dmem_addr];
`endif
    end
  end

endmodule

// File: tb/tb_divided_clock_memory_subsystem.sv
// Scoreboard bench for divided_clock_memory_subsystem: divider timing, ROM/RAM reads, write gating.
module tb_divided_clock_memory_subsystem;

    logic        clk = 1'b0;
    logic        reset;
    logic        clock_out, tick;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        dmem_wen;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_data_in, dmem_data_out;

    logic        rst3;
    logic        clock_out3, tick3;
    logic [11:0] imem_addr3 = '0;
    logic [31:0] imem_data3;
    logic        dmem_wen3 = 1'b0;
    logic [11:0] dmem_addr3 = '0;
    logic [31:0] dmem_data_in3 = '0;
    logic [31:0] dmem_data_out3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] imem;
        logic [31:0] dmem;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    divided_clock_memory_subsystem #(.DIV_HALF_PERIOD(1)) dut (
        .clock_in(clk), .reset(reset), .clock_out(clock_out), .tick(tick),
        .imem_addr(imem_addr), .imem_data(imem_data), .dmem_wen(dmem_wen),
        .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out)
    );

    divided_clock_memory_subsystem #(.DIV_HALF_PERIOD(3)) dut3 (
        .clock_in(clk), .reset(rst3), .clock_out(clock_out3), .tick(tick3),
        .imem_addr(imem_addr3), .imem_data(imem_data3), .dmem_wen(dmem_wen3),
        .dmem_addr(dmem_addr3), .dmem_data_in(dmem_data_in3), .dmem_data_out(dmem_data_out3)
    );

    function automatic logic [31:0] rom_model(input logic [11:0] a);
        if (a == 12'd0) return 32'h0000_0005;
        if (a == 12'd1) return 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One tick-edge transaction; expectations queued at drive time, compared after the edge,
    // then held across the following non-tick edge with different addresses presented.
    task automatic tick_op(input string name, input logic wen, input logic [11:0] addr,
                           input logic [31:0] din, input logic [11:0] iaddr,
                           input logic [31:0] exp_d);
        int   n = 0;
        exp_t e;
        while (tick !== 1'b1 && n < 10) begin
            step;
            n++;
        end
        if (tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: tick never asserted within 10 cycles", name);
            return;
        end
        dmem_wen = wen; dmem_addr = addr; dmem_data_in = din; imem_addr = iaddr;
        sb.push_back('{imem: rom_model(iaddr), dmem: exp_d});
        step;
        dmem_wen = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (imem_data !== e.imem) begin
            n_fail++;
            $display("FAIL %s imem: got %h expected %h", name, imem_data, e.imem);
        end
        n_checks++;
        if (dmem_data_out !== e.dmem) begin
            n_fail++;
            $display("FAIL %s dmem: got %h expected %h", name, dmem_data_out, e.dmem);
        end
        dmem_addr = addr ^ 12'h001;
        imem_addr = iaddr ^ 12'h001;
        step;
        n_checks++;
        if (dmem_data_out !== e.dmem || imem_data !== e.imem) begin
            n_fail++;
            $display("FAIL %s hold: got %h/%h expected %h/%h", name,
                     imem_data, dmem_data_out, e.imem, e.dmem);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; dmem_wen = 1'b1; dmem_addr = 12'h020; dmem_data_in = 32'hDEAD_BEEF;
        imem_addr = 12'd1;
        step;
        step;
        n_checks++;
        if (clock_out !== 1'b0 || imem_data !== 32'h0 || dmem_data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got clk=%b imem=%h dmem=%h expected 0/0/0",
                     clock_out, imem_data, dmem_data_out);
        end
        reset = 1'b0; dmem_wen = 1'b0; imem_addr = '0;
    endtask

    task automatic test_divider;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (tick !== logic'(k % 2)) begin
                n_fail++;
                $display("FAIL div1_tick edge %0d: got %b expected %b", k, tick, k % 2);
            end
            step;
            n_checks++;
            if (clock_out !== logic'(k % 2)) begin
                n_fail++;
                $display("FAIL div1_clock_out edge %0d: got %b expected %b", k, clock_out, k % 2);
            end
        end
    endtask

    task automatic test_divider3;
        logic exp;
        rst3 = 1'b1;
        step;
        rst3 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step;
            exp = logic'((k / 3) % 2);
            n_checks++;
            if (clock_out3 !== exp) begin
                n_fail++;
                $display("FAIL div3_clock_out edge %0d: got %b expected %b", k, clock_out3, exp);
            end
        end
        // Edge 16 is the second edge of a high phase; reset on the next edge truncates it.
        rst3 = 1'b1;
        step;
        rst3 = 1'b0;
        n_checks++;
        if (clock_out3 !== 1'b0 || tick3 !== 1'b0) begin
            n_fail++;
            $display("FAIL div3_midreset: got clk=%b tick=%b expected 0/0", clock_out3, tick3);
        end
        for (int k = 1; k <= 3; k++) begin
            step;
            exp = (k == 3);
            n_checks++;
            if (clock_out3 !== exp) begin
                n_fail++;
                $display("FAIL div3_after_reset edge %0d: got %b expected %b", k, clock_out3, exp);
            end
        end
    endtask

    task automatic test_rom;
        tick_op("rom_addr1", 1'b0, 12'h000, 32'h0, 12'd1, 32'h0);
        tick_op("rom_addr0", 1'b0, 12'h000, 32'h0, 12'd0, 32'h0);
        tick_op("rom_addr4095", 1'b0, 12'h000, 32'h0, 12'd4095, 32'h0);
    endtask

    task automatic test_ram;
`ifdef MEM_WRITE_THROUGH_EN
        tick_op("ram_write", 1'b1, 12'h00A, 32'h1234_5678, 12'd0, 32'h1234_5678);
`else
        tick_op("ram_write", 1'b1, 12'h00A, 32'h1234_5678, 12'd0, 32'h0);
`endif
        tick_op("ram_read_a", 1'b0, 12'h00A, 32'h0, 12'd1, 32'h1234_5678);
        tick_op("ram_read_b", 1'b0, 12'h00B, 32'h0, 12'd0, 32'h0);
    endtask

    task automatic test_read_during_write;
`ifdef MEM_WRITE_THROUGH_EN
        tick_op("rdw_set1", 1'b1, 12'h00A, 32'h1, 12'd0, 32'h1);
        tick_op("rdw_write2", 1'b1, 12'h00A, 32'h2, 12'd0, 32'h2);
`else
        tick_op("rdw_set1", 1'b1, 12'h00A, 32'h1, 12'd0, 32'h1234_5678);
        tick_op("rdw_write2", 1'b1, 12'h00A, 32'h2, 12'd0, 32'h1);
`endif
        tick_op("rdw_readback", 1'b0, 12'h00A, 32'h0, 12'd0, 32'h2);
    endtask

    task automatic test_non_tick_write;
        int n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step;
            n++;
        end
        step;
        dmem_wen = 1'b1; dmem_addr = 12'h030; dmem_data_in = 32'h0000_0BAD;
        n_checks++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL non_tick_phase: got tick=%b expected 0", tick);
        end
        step;
        dmem_wen = 1'b0;
        tick_op("non_tick_readback", 1'b0, 12'h030, 32'h0, 12'd0, 32'h0);
    endtask

    task automatic test_reset_write_suppressed;
        reset = 1'b1; dmem_wen = 1'b1; dmem_addr = 12'h021; dmem_data_in = 32'hCAFE_F00D;
        imem_addr = 12'd1;
        step;
        n_checks++;
        if (clock_out !== 1'b0 || imem_data !== 32'h0 || dmem_data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got clk=%b imem=%h dmem=%h expected 0/0/0",
                     clock_out, imem_data, dmem_data_out);
        end
        reset = 1'b0; dmem_wen = 1'b0;
        tick_op("reset_write_21", 1'b0, 12'h021, 32'h0, 12'd1, 32'h0);
        tick_op("reset_write_20", 1'b0, 12'h020, 32'h0, 12'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; rst3 = 1'b1;
        dmem_wen = 1'b0; dmem_addr = '0; dmem_data_in = '0; imem_addr = '0;
        #2;
        dut.rom[0] = 32'h0000_0005;
        dut.rom[1] = 32'hFFFF_FFFF;
        test_reset;
        test_divider;
        test_rom;
        test_ram;
        test_read_during_write;
        test_non_tick_write;
        test_reset_write_suppressed;
        test_divider3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
